ppt_placar: RTL

Match scorekeeper for rock-paper-scissors, sitting directly downstream of the combinational round judge. Each cycle in which `round_valid` is high it samples the judge's per-round win flags (`j1_w`, `j2_w`) and updates per-player scores. It declares a match winner when a player reaches `WINS_TO_MATCH` and then holds the result until cleared.

---
 rtl/ppt_pkg.sv | 28 ++
 rtl/ppt_score_cnt.sv | 30 +++
 rtl/ppt_placar.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ppt_pkg.sv
// Shared encodings for the rock-paper-scissors match path: the winner code,
// the scorekeeper state, and the round-result code that the judge also uses.
package ppt_pkg;

  // Match result as presented on the winner output
  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_J1   = 2'b01,
    W_J2   = 2'b10,
    W_DRAW = 2'b11
  } winner_t;

  // Scorekeeper state
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Round result as {j1_w, j2_w} from the judge
  typedef enum logic [1:0] {
    R_TIE     = 2'b00,
    R_J2      = 2'b01,
    R_J1      = 2'b10,
    R_ILLEGAL = 2'b11
  } round_t;

endpackage

// File: rtl/ppt_score_cnt.sv
// Saturation-free up counter used for the player scores and the tie streak.
// Clear takes priority over increment; the owner guarantees no wrap-around.
module ppt_score_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register: clear first, then increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ppt_placar.sv
// Match scorekeeper downstream of the round judge. Accepts one round per
// round_valid cycle while not DONE, tracks both scores, and freezes the
// result once a player reaches WINS_TO_MATCH until match_clear.
// Optional feature macro: PPT_TIE_LIMIT_EN -- a run of TIE_LIMIT consecutive
// ties ends the match as a draw. Without it ties never end a match and the
// tie-streak counter does not exist.
module ppt_placar
  import ppt_pkg::*;
#(
  parameter int unsigned WINS_TO_MATCH = 2,
  parameter int unsigned CNT_W         = 4
`ifdef PPT_TIE_LIMIT_EN
  , parameter int unsigned TIE_LIMIT   = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             round_valid,
  input  logic             j1_w,
  input  logic             j2_w,
  input  logic             match_clear,
  output logic             round_ready,
  output logic [CNT_W-1:0] score1,
  output logic [CNT_W-1:0] score2,
  output logic             match_done,
  output logic [1:0]       winner,
  output logic             err
);

  state_t     state_r;
  winner_t    winner_r;
  logic       done_r;
  logic       err_r;

  logic       ready_s;
  logic       accept_s;
  logic       inc1_s;
  logic       inc2_s;
  logic       tie_s;
  logic       illegal_s;
  logic       win1_s;
  logic       win2_s;
  logic       draw_s;
  round_t     round_s;

  assign ready_s  = (state_r != S_DONE);
  // A clear on the same edge drops the round entirely
  assign accept_s = round_valid && ready_s && !match_clear;
  assign round_s  = round_t'({j1_w, j2_w});

  // Decode the accepted round into score/tie/illegal events
  always_comb begin
    inc1_s    = 1'b0;
    inc2_s    = 1'b0;
    tie_s     = 1'b0;
    illegal_s = 1'b0;
    if (accept_s) begin
      case (round_s)
        R_J1:      inc1_s    = 1'b1;
        R_J2:      inc2_s    = 1'b1;
        R_TIE:     tie_s     = 1'b1;
        R_ILLEGAL: illegal_s = 1'b1;
        default:   illegal_s = 1'b1;
      endcase
    end else begin
      inc1_s    = 1'b0;
      inc2_s    = 1'b0;
      tie_s     = 1'b0;
      illegal_s = 1'b0;
    end
  end

  // A win is detected on the increment that lands on WINS_TO_MATCH
  assign win1_s = inc1_s && (score1 == CNT_W'(WINS_TO_MATCH - 32'd1));
  assign win2_s = inc2_s && (score2 == CNT_W'(WINS_TO_MATCH - 32'd1));

  ppt_score_cnt #(.W(CNT_W)) u_score1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (match_clear),
    .inc   (inc1_s),
    .cnt   (score1)
  );

  ppt_score_cnt #(.W(CNT_W)) u_score2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (match_clear),
    .inc   (inc2_s),
    .cnt   (score2)
  );

`ifdef PPT_TIE_LIMIT_EN
  logic [CNT_W-1:0] tie_cnt_s;
  logic             tie_clr_s;

  // Decisive rounds break the streak; illegal rounds leave it alone
  assign tie_clr_s = match_clear || inc1_s || inc2_s;
  assign draw_s    = tie_s && (tie_cnt_s == CNT_W'(TIE_LIMIT - 32'd1));

  ppt_score_cnt #(.W(CNT_W)) u_tie_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tie_clr_s),
    .inc   (tie_s),
    .cnt   (tie_cnt_s)
  );
`else
  assign draw_s = 1'b0;
`endif

  // Match FSM with registered result, done and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      winner_r <= W_NONE;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else if (match_clear) begin
      state_r  <= S_IDLE;
      winner_r <= W_NONE;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_PLAY: begin
          if (accept_s) begin
            if (illegal_s) begin
              err_r <= 1'b1;
            end
            if (win1_s) begin
              state_r  <= S_DONE;
              winner_r <= W_J1;
              done_r   <= 1'b1;
            end else if (win2_s) begin
              state_r  <= S_DONE;
              winner_r <= W_J2;
              done_r   <= 1'b1;
            end else if (draw_s) begin
              state_r  <= S_DONE;
              winner_r <= W_DRAW;
              done_r   <= 1'b1;
            end else begin
              state_r  <= S_PLAY;
            end
          end
        end
        S_DONE: begin
          state_r <= S_DONE;
        end
        default: begin
          state_r  <= S_IDLE;
          winner_r <= W_NONE;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign round_ready = ready_s;
  assign match_done  = done_r;
  assign winner      = winner_r;
  assign err         = err_r;

endmodule
